// File: rtl/odo_pkg.sv
// Shared constants for the shaft odometer: completion-mode codes, FSM state
// encoding and default conditioning/stall timing.
package odo_pkg;

    localparam logic [1:0] ODO_BOTH  = 2'b00;
    localparam logic [1:0] ODO_AVG   = 2'b01;
    localparam logic [1:0] ODO_LEFT  = 2'b10;
    localparam logic [1:0] ODO_RIGHT = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;
    localparam logic [1:0] ST_STALL = 2'b11;

    localparam int ODO_FILTER_CYCLES = 500;
    localparam int ODO_STALL_CYCLES  = 25_000_000;

endpackage

// File: rtl/shaft_pulse_filter.sv
// One encoder pin: 2-FF synchronizer, consecutive-sample glitch filter and a
// one-cycle strobe on each filtered rising edge.
module shaft_pulse_filter
    import odo_pkg::*;
#(
    parameter int FILTER_CYCLES = ODO_FILTER_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic strobe
);

    localparam int FW = $clog2(FILTER_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [FW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            count   <= '0;
            strobe  <= 1'b0;
        end else begin
            sync1   <= pin;
            sync2   <= sync1;
            level_d <= level;
            strobe  <= level & ~level_d;
            // Any sample agreeing with the accepted level restarts the qualification run.
            if (sync2 == level) begin
                count <= '0;
            end else if (count == FW'(FILTER_CYCLES - 1)) begin
                level <= sync2;
                count <= '0;
            end else begin
                count <= count + FW'(1);
            end
        end
    end

endmodule

// File: rtl/shaft_odometer.sv
// Distance-based wheel travel measurement with a command/done/stall handshake.
// Optional stall watchdog enabled by defining ODO_STALL_EN.
module shaft_odometer
    import odo_pkg::*;
#(
    parameter int CNT_W         = 16,
    parameter int FILTER_CYCLES = ODO_FILTER_CYCLES,
    parameter int STALL_CYCLES  = ODO_STALL_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shaftPulseL,
    input  logic             shaftPulseR,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_target,
    input  logic [1:0]       cmd_mode,
    input  logic             cmd_abort,
    output logic             done,
    output logic             stall,
    output logic             busy,
    output logic [CNT_W-1:0] cnt_l,
    output logic [CNT_W-1:0] cnt_r
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state_reg;
    logic [CNT_W-1:0] target_reg;
    logic [1:0]       mode_reg;
    logic             accept;
    logic             complete;
    logic             stall_hit;
    logic [1:0]       pins;
    logic [1:0]       strobes;
    logic [CNT_W-1:0] counts [2];
    logic [CNT_W:0]   sum;

    assign accept = cmd_valid && (state_reg == ST_IDLE);
    assign pins   = {shaftPulseR, shaftPulseL};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_wheel
            logic [CNT_W-1:0] count_reg;

            shaft_pulse_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter (
                .clk    (clk),
                .rst    (rst),
                .pin    (pins[gi]),
                .strobe (strobes[gi])
            );

            // Accept clears the counter and swallows a coincident strobe.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    count_reg <= '0;
                end else if (accept) begin
                    count_reg <= '0;
                end else if (strobes[gi] && (count_reg != CNT_MAX)) begin
                    count_reg <= count_reg + CNT_W'(1);
                end
            end

            assign counts[gi] = count_reg;
        end
    endgenerate

    assign cnt_l = counts[0];
    assign cnt_r = counts[1];
    assign sum   = {1'b0, cnt_l} + {1'b0, cnt_r};

    always_comb begin
        complete = 1'b0;
        case (mode_reg)
            ODO_BOTH:  complete = (cnt_l >= target_reg) && (cnt_r >= target_reg);
            ODO_AVG:   complete = (sum[CNT_W:1] >= target_reg);
            ODO_LEFT:  complete = (cnt_l >= target_reg);
            default:   complete = (cnt_r >= target_reg);
        endcase
    end

`ifdef ODO_STALL_EN
    localparam int TW = $clog2(STALL_CYCLES + 1);

    logic [TW-1:0] timer_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_reg <= '0;
        end else if (accept || (|strobes)) begin
            timer_reg <= '0;
        end else if (state_reg == ST_RUN) begin
            timer_reg <= timer_reg + TW'(1);
        end
    end

    assign stall_hit = (state_reg == ST_RUN) && (timer_reg == TW'(STALL_CYCLES - 1));
    assign stall     = (state_reg == ST_STALL);
`else
    // No watchdog in this build; the limit parameter stays for a uniform interface.
    assign stall_hit = (STALL_CYCLES < 0);
    assign stall     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            target_reg <= '0;
            mode_reg   <= ODO_BOTH;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        state_reg  <= ST_RUN;
                        target_reg <= cmd_target;
                        mode_reg   <= cmd_mode;
                    end
                end
                // Abort beats completion, completion beats stall.
                ST_RUN: begin
                    if (cmd_abort) begin
                        state_reg <= ST_IDLE;
                    end else if (complete) begin
                        state_reg <= ST_DONE;
                    end else if (stall_hit) begin
                        state_reg <= ST_STALL;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_reg == ST_IDLE);
    assign busy      = (state_reg == ST_RUN);
    assign done      = (state_reg == ST_DONE);

endmodule

// File: tb/tb_shaft_odometer.sv
// Scoreboard bench for shaft_odometer: stimulus pushes expected command outcomes,
// a monitor pops them whenever the block leaves RUN.
module tb_shaft_odometer;

    localparam int F = 4;
    localparam int S = 64;

    typedef struct {
        int kind;   // 0 abort, 1 done, 2 stall
        int l;
        int r;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pin_l = 1'b0;
    logic        pin_r = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [15:0] cmd_target = '0;
    logic [1:0]  cmd_mode = '0;
    logic        cmd_abort = 1'b0;
    logic        cmd_ready, done, stall, busy;
    logic [15:0] cnt_l, cnt_r;

    logic        cmd_valid4 = 1'b0;
    logic [3:0]  cmd_target4 = '0;
    logic        cmd_ready4, done4, stall4, busy4;
    logic [3:0]  cnt_l4, cnt_r4;

    int   total = 0;
    int   bad = 0;
    int   left_total = 0;
    int   right_total = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    shaft_odometer #(.CNT_W(16), .FILTER_CYCLES(F), .STALL_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .shaftPulseL(pin_l), .shaftPulseR(pin_r),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_target(cmd_target),
        .cmd_mode(cmd_mode), .cmd_abort(cmd_abort), .done(done), .stall(stall),
        .busy(busy), .cnt_l(cnt_l), .cnt_r(cnt_r)
    );

    shaft_odometer #(.CNT_W(4), .FILTER_CYCLES(F), .STALL_CYCLES(S)) dut4 (
        .clk(clk), .rst(rst), .shaftPulseL(pin_l), .shaftPulseR(pin_r),
        .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4), .cmd_target(cmd_target4),
        .cmd_mode(2'b10), .cmd_abort(1'b0), .done(done4), .stall(stall4),
        .busy(busy4), .cnt_l(cnt_l4), .cnt_r(cnt_r4)
    );

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic bit model_done(input logic [1:0] mode, input int t, input int l, input int r);
        case (mode)
            2'b00:   return ((l < r ? l : r) >= t);
            2'b01:   return (((l + r) / 2) >= t);
            2'b10:   return (l >= t);
            default: return (r >= t);
        endcase
    endfunction

    task automatic push_exp(input int kind, input int l, input int r);
        exp_t e;
        e.kind = kind;
        e.l = l;
        e.r = r;
        sbq.push_back(e);
    endtask

    // Monitor: every exit from RUN is one transaction.
    initial begin
        bit   busy_prev;
        int   kind;
        exp_t e;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_prev = 1'b0;
            end else begin
                if (busy_prev && !busy) begin
                    kind = done ? 1 : (stall ? 2 : 0);
                    $display("txn end kind=%0d cnt_l=%0d cnt_r=%0d", kind, cnt_l, cnt_r);
                    if (sbq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_event actual_kind=%0d required=none", kind);
                    end else begin
                        e = sbq.pop_front();
                        check("event_kind", kind, e.kind);
                        check("event_cnt_l", int'(cnt_l), e.l);
                        check("event_cnt_r", int'(cnt_r), e.r);
                    end
                end
                busy_prev = busy;
            end
        end
    end

    task automatic pulse(input bit right);
        @(negedge clk);
        if (right) pin_r = 1'b1; else pin_l = 1'b1;
        repeat (10) @(negedge clk);
        pin_l = 1'b0;
        pin_r = 1'b0;
        repeat (10) @(negedge clk);
        if (right) right_total++; else left_total++;
    endtask

    task automatic wait_ready(input string name, input int budget);
        int n = 0;
        while (!cmd_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(cmd_ready), 1);
    endtask

    task automatic accept(input logic [1:0] mode, input int target);
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_mode   = mode;
        cmd_target = 16'(target);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic do_abort();
        @(negedge clk);
        cmd_abort = 1'b1;
        @(negedge clk);
        cmd_abort = 1'b0;
    endtask

    task automatic run_cmd(input logic [1:0] mode, input int target, input int n,
                           input logic [31:0] seq, input bit final_abort);
        int l = 0;
        int r = 0;
        int stop = -1;
        bit use_abort = final_abort;
`ifndef ODO_STALL_EN
        use_abort = 1'b1;
`endif
        if (model_done(mode, target, 0, 0)) begin
            stop = 0;
        end else begin
            for (int i = 0; i < n; i++) begin
                if (seq[i]) r++; else l++;
                if (model_done(mode, target, l, r)) begin
                    stop = i + 1;
                    break;
                end
            end
        end
        $display("txn start mode=%0d target=%0d pulses=%0d seq=%08h exp_l=%0d exp_r=%0d hit=%0d",
                 mode, target, n, seq, l, r, stop);
        wait_ready("ready_before_cmd", 100);
        if (stop >= 0) begin
            push_exp(1, l, r);
            accept(mode, target);
            for (int i = 0; i < stop; i++) pulse(seq[i]);
            wait_ready("ready_after_done", 50);
        end else begin
            accept(mode, target);
            for (int i = 0; i < n; i++) pulse(seq[i]);
            if (use_abort) begin
                push_exp(0, l, r);
                do_abort();
                wait_ready("ready_after_abort", 10);
            end else begin
                push_exp(2, l, r);
                wait_ready("ready_after_stall", S + 60);
            end
        end
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("reset_cnt_l", int'(cnt_l), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_cmd_ready", int'(cmd_ready), 1);
        check("reset_done", int'(done), 0);
        check("reset_stall", int'(stall), 0);
        rst = 1'b0;

        // Reset in the middle of a command.
        wait_ready("ready_pre_reset", 10);
        accept(2'b10, 10);
        for (int i = 0; i < 3; i++) pulse(1'b0);
        check("cnt_l_before_reset", int'(cnt_l), 3);
        check("busy_before_reset", int'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_cnt_l", int'(cnt_l), 0);
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_cmd_ready", int'(cmd_ready), 1);
        check("async_reset_done", int'(done), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Arm the narrow-counter instance for the saturation check.
        @(negedge clk);
        cmd_valid4 = 1'b1;
        @(negedge clk);
        cmd_valid4 = 1'b0;
        left_total = 0;
        right_total = 0;

        // Target 0 completes straight away.
        run_cmd(2'b10, 0, 0, 32'h0, 1'b0);

        // Glitch rejection and strobe latency while idle.
        @(negedge clk);
        pin_l = 1'b1;
        repeat (3) @(negedge clk);
        pin_l = 1'b0;
        repeat (20) @(negedge clk);
        check("glitch_reject", int'(cnt_l), 0);
        @(negedge clk);
        pin_l = 1'b1;
        n = 0;
        while (cnt_l == 16'd0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("strobe_to_count_clocks", n, F + 3 + 1);
        repeat (12) @(negedge clk);
        pin_l = 1'b0;
        repeat (10) @(negedge clk);
        left_total++;
        check("clean_pulse_count", int'(cnt_l), 1);

        run_cmd(2'b10, 5, 5, 32'h0, 1'b1);
        run_cmd(2'b00, 3, 8, 32'hE0, 1'b1);
        run_cmd(2'b01, 3, 6, 32'h30, 1'b1);
        run_cmd(2'b11, 2, 4, 32'hA, 1'b1);

`ifdef ODO_STALL_EN
        wait_ready("ready_before_stall", 10);
        push_exp(2, 0, 0);
        accept(2'b10, 10);
        n = 0;
        while (!stall && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("stall_latency", n, S);
        wait_ready("ready_after_stall_dir", 10);
`else
        wait_ready("ready_before_nostall", 10);
        accept(2'b10, 10);
        repeat (200) @(negedge clk);
        check("busy_without_stall", int'(busy), 1);
        push_exp(0, 0, 0);
        do_abort();
        wait_ready("ready_after_nostall", 10);
`endif

        // Abort in the same cycle the target is met.
        wait_ready("ready_before_abort_hit", 10);
        push_exp(0, 1, 0);
        accept(2'b10, 1);
        fork
            pulse(1'b0);
            begin
                int k = 0;
                while (cnt_l == 16'd0 && k < 40) begin
                    @(negedge clk);
                    k++;
                end
                cmd_abort = 1'b1;
                @(negedge clk);
                cmd_abort = 1'b0;
            end
        join
        wait_ready("ready_after_abort_hit", 10);

        repeat (12) begin
            run_cmd(2'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 8)), 32'($urandom), 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sbq.size(), 0);
        check("saturate_cnt_l", int'(cnt_l4), left_total > 15 ? 15 : left_total);
        check("saturate_cnt_r", int'(cnt_r4), right_total > 15 ? 15 : right_total);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        total++;
        bad++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shaft_odometer.md
Name: shaft_odometer

Overview:
Measures wheel travel from the left and right shaft-encoder pulse inputs. It conditions the raw pins and counts clean rising edges per wheel. It accepts a distance command from the drive state machine and returns a one-cycle completion or stall indication. It sits directly upstream of the drive/junction controller and replaces its time-based junction manoeuvres with distance-based ones.

Parameters:
CNT_W, 16, width of per-wheel pulse counters and of the command target
FILTER_CYCLES, 500, consecutive stable synchronized samples required to accept a pin level change (10 us at 50 MHz)
STALL_CYCLES, 25_000_000, clocks without any counted edge in RUN before stall is declared (0.5 s)

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous, active-high reset
shaftPulseL  in  1  raw left encoder pin, asynchronous to clk
shaftPulseR  in  1  raw right encoder pin, asynchronous to clk
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_target  in  CNT_W  required pulse count
cmd_mode  in  2  completion rule: 00 BOTH, 01 AVG, 10 LEFT, 11 RIGHT
cmd_abort  in  1  cancel the active command
done  out  1  one-cycle pulse on target reached
stall  out  1  one-cycle pulse on stall abort
busy  out  1  high in RUN
cnt_l  out  CNT_W  left edges since command accept
cnt_r  out  CNT_W  right edges since command accept

Behaviour:
- Reset (asynchronous): state IDLE; cnt_l, cnt_r, done, stall, busy = 0; cmd_ready = 1; synchronizer and filter state = 0; stall timer = 0.
- Pin conditioning, per wheel:
  - 2-FF synchronizer, then filter counter. The filtered level changes only after FILTER_CYCLES consecutive synchronized samples that differ from the current filtered level.
  - Any sample that agrees with the filtered level clears the filter counter.
  - A filtered 0->1 transition produces a one-cycle edge strobe.
  - Latency from a clean pin rise to the strobe is 2 + FILTER_CYCLES + 1 clocks.
- Counting:
  - On a strobe, the wheel's counter increments, saturating at 2^CNT_W-1.
  - Counters run in every state and are cleared only on command accept.
- Handshake:
  - Accept occurs when cmd_valid && cmd_ready at a clock edge.
  - On accept: latch target and mode, clear both counters and the stall timer, go to RUN.
  - A strobe arriving on the accept cycle is discarded.
- RUN completion, evaluated every cycle on the registered counts:
  - BOTH: min(cnt_l, cnt_r) >= target
  - AVG: (cnt_l + cnt_r) >> 1 >= target, summed at CNT_W+1 bits (no overflow)
  - LEFT: cnt_l >= target
  - RIGHT: cnt_r >= target
  - Condition true -> DONE.
  - Target 0 completes on the first RUN cycle.
- DONE: done = 1 for exactly one cycle, then IDLE. Counters hold their values until the next accept.
- STALL: stall = 1 for exactly one cycle, then IDLE.
- Stall timer:
  - Increments each RUN cycle and clears on any strobe.
  - Reaching STALL_CYCLES-1 -> STALL.
  - If completion and the stall limit occur in the same cycle, completion wins.
- Abort: cmd_abort in RUN -> IDLE next cycle with no done and no stall pulse. Abort takes priority over completion and stall in the same cycle. Abort is ignored outside RUN.
- busy = (state == RUN). cmd_valid is ignored outside IDLE.
- Reset asserted mid-command returns the block to the reset values immediately. No pulse is emitted.

Optional Feature:
- Macro ODO_STALL_EN.
- Defined: stall timer and STALL state present, as described above.
- Undefined: no timer; the stall output is tied to 0; RUN exits only on completion or abort.

Decomposition:
- Shared package odo_pkg holds:
  - mode codes ODO_BOTH, ODO_AVG, ODO_LEFT, ODO_RIGHT
  - state encoding IDLE/RUN/DONE/STALL
  - default FILTER_CYCLES and STALL_CYCLES constants
- One sub-module, shaft_pulse_filter: synchronizer, glitch filter and rising-edge strobe, parameterized by FILTER_CYCLES. Instantiated once per wheel.

Test Plan (FILTER_CYCLES=4, STALL_CYCLES=64 for sim):
- Reset mid-RUN with cnt_l=3 -> cnt_l=0, busy=0, cmd_ready=1 asynchronously; no done/stall pulse.
- Glitch rejection: 3-clock high pulse on shaftPulseL -> cnt_l stays 0. A 20-clock high pulse -> cnt_l=1, strobe 7 clocks after the rise.
- LEFT mode, target 5, five clean left pulses, no right pulses -> done one cycle after cnt_l reaches 5; cmd_ready returns the next cycle.
- BOTH mode, target 3, left 5 pulses, right 2 pulses -> no done. A 3rd right pulse -> done. AVG mode, target 3, L=4 R=2 -> done.
- Stall (ODO_STALL_EN defined), target 10, no pulses -> stall pulse after 64 RUN cycles; done never asserted. With the macro undefined -> busy remains 1 after 200 cycles.
- Abort, and saturation:
  - cmd_abort on the same cycle the target is met -> IDLE, done=0.
  - Target 0 -> done on the 2nd cycle after accept.
  - CNT_W=4 with 20 pulses -> counter saturates at 15.
